uart_parity_tx: RTL

UART_PARITY_TX -- requirements
Module: uart_parity_tx

---
 rtl/uart_parity_tx_pkg.sv | 37 +++
 rtl/uart_baud_tick.sv | 36 +++
 rtl/uart_parity_tx.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/uart_parity_tx_pkg.sv
// Shared types and constants for the parity UART transmitter:
// FSM state encoding, baud divisors and baud-select codes.
package uart_parity_tx_pkg;

   localparam int unsigned DIV_W = 9;

   localparam logic [DIV_W-1:0] DIV_434 = 9'd434;
   localparam logic [DIV_W-1:0] DIV_217 = 9'd217;
   localparam logic [DIV_W-1:0] DIV_109 = 9'd109;
   localparam logic [DIV_W-1:0] DIV_72  = 9'd72;
   localparam logic [DIV_W-1:0] DIV_36  = 9'd36;

   localparam logic [2:0] BC_217 = 3'b001;
   localparam logic [2:0] BC_109 = 3'b010;
   localparam logic [2:0] BC_72  = 3'b011;
   localparam logic [2:0] BC_36  = 3'b100;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   // Unlisted select codes fall back to the slowest rate.
   function automatic logic [DIV_W-1:0] bc_to_div(input logic [2:0] bc);
      case (bc)
         BC_217:  return DIV_217;
         BC_109:  return DIV_109;
         BC_72:   return DIV_72;
         BC_36:   return DIV_36;
         default: return DIV_434;
      endcase
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud generator: counts 0..N and emits a one-clk tick per bit period
// (N+1 clks). The divisor is re-registered every clk from BC.
module uart_baud_tick
   import uart_parity_tx_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] BC,
   output logic       tick
);

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      div_q <= bc_to_div(BC);
   end

   // A count stranded above a freshly lowered divisor restarts silently.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         tick  <= 1'b0;
      end else if (cnt_q == div_q) begin
         cnt_q <= '0;
         tick  <= 1'b1;
      end else if (cnt_q > div_q) begin
         cnt_q <= '0;
         tick  <= 1'b0;
      end else begin
         cnt_q <= cnt_q + DIV_W'(1);
         tick  <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_parity_tx.sv
// UART transmitter with a byte FIFO, optional even-parity bit and
// frame abort. Line and status outputs are registered.
module uart_parity_tx
   import uart_parity_tx_pkg::*;
#(
   parameter int unsigned DEPTH     = 4,
   parameter bit          PARITY_EN = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [2:0]              BC,
   input  logic [7:0]              tx_data,
   input  logic                    tx_valid,
   output logic                    tx_ready,
   input  logic                    abort,
   output logic                    tx_out,
   output logic                    busy,
   output logic [$clog2(DEPTH):0]  fifo_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic tick;

   uart_baud_tick u_baud (
      .clk   (clk),
      .reset (reset),
      .BC    (BC),
      .tick  (tick)
   );

   // ---------------- transmit FIFO ----------------
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count_next;
   logic [7:0]    fifo_head;
   logic          fifo_empty;
   logic          push;
   logic          pop;

   assign push       = tx_valid && tx_ready;
   assign fifo_empty = (fifo_count == '0);
   assign fifo_head  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!reset && push) begin
         mem[wr_ptr] <= tx_data;
      end
   end

   always_comb begin
      count_next = fifo_count;
      case ({push, pop})
         2'b10:   count_next = fifo_count + CW'(1);
         2'b01:   count_next = fifo_count - CW'(1);
         default: count_next = fifo_count;
      endcase
   end

   // tx_ready is registered from the next count so it always equals count < DEPTH.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         tx_ready   <= 1'b1;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         fifo_count <= count_next;
         tx_ready   <= (count_next < CW'(DEPTH));
      end
   end

   // ---------------- framing FSM ----------------
   tx_state_t  state;
   tx_state_t  state_next;
   logic [2:0] bit_idx;
   logic [2:0] bit_idx_next;
   logic [7:0] shift_q;
   logic [7:0] shift_next;
   logic       parity_q;
   logic       parity_next;
   logic       tx_out_next;
   logic       busy_next;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         bit_idx  <= '0;
         shift_q  <= '0;
         parity_q <= 1'b0;
         tx_out   <= 1'b1;
         busy     <= 1'b0;
      end else begin
         state    <= state_next;
         bit_idx  <= bit_idx_next;
         shift_q  <= shift_next;
         parity_q <= parity_next;
         tx_out   <= tx_out_next;
         busy     <= busy_next;
      end
   end

   // Transitions only on a baud tick; abort overrides and drops the frame.
   always_comb begin
      state_next   = state;
      bit_idx_next = bit_idx;
      shift_next   = shift_q;
      parity_next  = parity_q;
      pop          = 1'b0;
      if (abort) begin
         state_next   = ST_IDLE;
         bit_idx_next = '0;
         shift_next   = '0;
         parity_next  = 1'b0;
      end else if (tick) begin
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  pop = 1'b1;
               end
            end
            ST_START: begin
               state_next   = ST_DATA;
               bit_idx_next = '0;
            end
            ST_DATA: begin
               if (bit_idx == 3'd7) begin
                  bit_idx_next = '0;
                  state_next   = PARITY_EN ? ST_PARITY : ST_STOP;
               end else begin
                  bit_idx_next = bit_idx + 3'd1;
               end
            end
            ST_PARITY: begin
               state_next = ST_STOP;
            end
            ST_STOP: begin
               if (!fifo_empty) begin
                  pop = 1'b1;
               end else begin
                  state_next = ST_IDLE;
               end
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
         if (pop) begin
            state_next   = ST_START;
            shift_next   = fifo_head;
            parity_next  = ^fifo_head;
            bit_idx_next = '0;
         end
      end
   end

   // Line level follows the next state so it moves one clk after the tick.
   always_comb begin
      tx_out_next = 1'b1;
      busy_next   = (state_next != ST_IDLE);
      case (state_next)
         ST_START:  tx_out_next = 1'b0;
         ST_DATA:   tx_out_next = shift_next[bit_idx_next];
         ST_PARITY: tx_out_next = parity_next;
         default:   tx_out_next = 1'b1;
      endcase
   end

endmodule
